// File: rtl/ram_64.sv
// ram_64: 64x16 register-file RAM built as 8 banks of 8 words, async read, sync write.
// Defining RAM64_WRITE_THROUGH_EN makes out follow value while load=1 (write-first view).
module ram_64 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  input  logic [5:0]       address,
  output logic [WIDTH-1:0] out
);
  localparam int BANKS = DEPTH / 8;
  logic [BANKS-1:0][WIDTH-1:0] bank_rd;
  logic [WIDTH-1:0] rd;
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] words_q [8];
    logic we;
    assign we = load && (address[5:3] == 3'(b));
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) for (int w = 0; w < 8; w++) words_q[w] <= '0;
      else if (we) words_q[address[2:0]] <= value;
    assign bank_rd[b] = words_q[address[2:0]];
  end
  assign rd = bank_rd[address[5:3]];
`ifdef RAM64_WRITE_THROUGH_EN
  assign out = load ? value : rd;
`else
  assign out = rd;
`endif
endmodule

// File: tb/tb_ram_64.sv
// tb_ram_64: randomized and directed checks of ram_64 against an array reference model.
module tb_ram_64;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [15:0] value = '0;
  logic        load = 0;
  logic [5:0]  address = '0;
  logic [15:0] out;
  logic [15:0] ref_mem [64];
  int n_checks = 0;
  int n_fail = 0;

  ram_64 dut (.clk(clk), .rst_n(rst_n), .value(value), .load(load), .address(address), .out(out));

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_out();
`ifdef RAM64_WRITE_THROUGH_EN
    return load ? value : ref_mem[address];
`else
    return ref_mem[address];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n && load) ref_mem[address] = value;
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] v);
    address = a; value = v; load = 1;
    tick();
    load = 0;
  endtask

  task automatic rd_check(input string name, input logic [5:0] a, input logic [15:0] e);
    address = a; #1;
    n_checks++;
    if (out !== e) begin
      n_fail++;
      $display("FAIL %s addr=%0d got=%h exp=%h", name, a, out, e);
    end
  endtask

  task automatic test_reset();
    logic [5:0] addrs [4] = '{6'd0, 6'd3, 6'd45, 6'd63};
    rst_n = 1;
    tick();
    for (int i = 0; i < 20; i++) wr(6'($urandom), 16'($urandom) | 16'h1);
    #2 rst_n = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    #1;
    for (int i = 0; i < 4; i++) rd_check("reset_read", addrs[i], 16'h0000);
    for (int i = 0; i < 64; i++) begin
      address = 6'(i); #1;
      n_checks++;
      if (out !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_all addr=%0d got=%h exp=0000", i, out);
      end
    end
    rst_n = 1; #1;
  endtask

  task automatic test_write_read();
    wr(6'd3, 16'h0003);
    wr(6'd45, 16'h000F);
    rd_check("wr_rd3", 6'd3, 16'h0003);
    rd_check("wr_rd45", 6'd45, 16'h000F);
    rd_check("wr_rd3b", 6'd3, 16'h0003);
  endtask

  task automatic test_hold();
    address = 6'd3; value = 16'hFFFF; load = 0;
    repeat (4) tick();
    rd_check("hold3", 6'd3, 16'h0003);
    for (int i = 0; i < 64; i++) rd_check("hold_all", 6'(i), ref_mem[i]);
  endtask

  task automatic test_bank_boundary();
    wr(6'd7, 16'hA5A5);
    wr(6'd8, 16'h5A5A);
    rd_check("bnd7", 6'd7, 16'hA5A5);
    rd_check("bnd8", 6'd8, 16'h5A5A);
    rd_check("bnd15", 6'd15, 16'h0000);
  endtask

  task automatic test_reset_midcycle();
    wr(6'd63, 16'h1234);
    rd_check("pre_rst63", 6'd63, 16'h1234);
    #2 rst_n = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    #1;
    rd_check("async_rst63", 6'd63, 16'h0000);
    load = 1; value = 16'h1234;
    tick();
    load = 0;
    rd_check("wr_in_rst63", 6'd63, 16'h0000);
    #2 rst_n = 1; #1;
    rd_check("post_rst63", 6'd63, 16'h0000);
    wr(6'd63, 16'h4321);
    rd_check("first_wr63", 6'd63, 16'h4321);
  endtask

  task automatic test_read_during_write();
    address = 6'd10; value = 16'hBEEF; load = 1; #1;
    n_checks++;
    if (out !== exp_out()) begin
      n_fail++;
      $display("FAIL rdw_before got=%h exp=%h", out, exp_out());
    end
    tick();
    n_checks++;
    if (out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rdw_after got=%h exp=beef", out);
    end
    load = 0;
    rd_check("rdw_stored", 6'd10, 16'hBEEF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      address = 6'($urandom); value = 16'($urandom); load = ($urandom_range(0, 2) != 0);
      #1;
      n_checks++;
      if (out !== exp_out()) begin
        n_fail++;
        $display("FAIL rand_pre it=%0d addr=%0d load=%0b got=%h exp=%h", i, address, load, out, exp_out());
      end
      tick();
    end
    load = 0;
    for (int i = 0; i < 64; i++) rd_check("rand_final", 6'(i), ref_mem[i]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    #2;
    test_reset();
    test_write_read();
    test_hold();
    test_bank_boundary();
    test_reset_midcycle();
    test_read_during_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
